// File: rtl/booth_divider_pkg.sv
// Shared definitions for the sequential signed divider: widths and controller states.
package div_pkg;
   localparam int WIDTH_IN       = 16;
   localparam int WIDTH_DIVIDEND = 2 * WIDTH_IN;
   localparam int WIDTH_PR       = WIDTH_IN + 1;
   localparam int CNT_W          = $clog2(WIDTH_DIVIDEND);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } div_state_e;
endpackage

// File: rtl/booth_divider_if.sv
// Issue/result bundle shared with the Booth multiplier's valid_in/valid_out convention.
interface booth_divider_if #(
   parameter int WIDTH_IN       = div_pkg::WIDTH_IN,
   parameter int WIDTH_DIVIDEND = div_pkg::WIDTH_DIVIDEND
);
   logic                             valid_in;
   logic signed [WIDTH_DIVIDEND-1:0] in_dividend;
   logic signed [WIDTH_IN-1:0]       in_divisor;
   logic                             ready_out;
   logic                             valid_out;
   logic signed [WIDTH_DIVIDEND-1:0] quotient;
   logic signed [WIDTH_IN-1:0]       remainder;
   logic                             div_by_zero;
   logic                             overflow;

   modport master (
      output valid_in, in_dividend, in_divisor,
      input  ready_out, valid_out, quotient, remainder, div_by_zero, overflow
   );

   modport slave (
      input  valid_in, in_dividend, in_divisor,
      output ready_out, valid_out, quotient, remainder, div_by_zero, overflow
   );
endinterface

// File: rtl/booth_divider_controller.sv
// Sequencer for the divider: state register, iteration counter and datapath enables.
module div_controller #(
   parameter int WIDTH_DIVIDEND = div_pkg::WIDTH_DIVIDEND
) (
   input  logic clk,
   input  logic reset,
   input  logic valid_in,
   output logic ready_out,
   output logic valid_out,
   output logic capture,
   output logic shift,
   output logic fix
);
   import div_pkg::*;

   localparam int               CNT_W    = $clog2(WIDTH_DIVIDEND);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH_DIVIDEND - 1);

   div_state_e       state;
   div_state_e       state_next;
   logic [CNT_W-1:0] count;

   // valid_out is registered off DONE, so the pulse lands WIDTH_DIVIDEND+2 edges after acceptance
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= '0;
         valid_out <= 1'b0;
      end else begin
         state     <= state_next;
         valid_out <= (state == DONE);
         if (capture)
            count <= CNT_LOAD;
         else if (shift)
            count <= count - 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      ready_out  = 1'b0;
      capture    = 1'b0;
      shift      = 1'b0;
      fix        = 1'b0;
      case (state)
         IDLE: begin
            ready_out = 1'b1;
            if (valid_in) begin
               capture    = 1'b1;
               state_next = CALC;
            end
         end
         CALC: begin
            shift = 1'b1;
            if (count == '0)
               state_next = FIX;
         end
         FIX: begin
            fix        = 1'b1;
            state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: rtl/booth_divider.sv
// Signed restoring divider datapath: magnitude shift/subtract, then sign fix-up into held outputs.
module booth_divider #(
   parameter int WIDTH_IN       = div_pkg::WIDTH_IN,
   parameter int WIDTH_DIVIDEND = div_pkg::WIDTH_DIVIDEND,
   parameter int WIDTH_PR       = div_pkg::WIDTH_PR
) (
   input logic            clk,
   input logic            reset,
   booth_divider_if.slave bus
);
   import div_pkg::*;

   logic                      capture;
   logic                      shift;
   logic                      fix;
   logic [WIDTH_DIVIDEND-1:0] dq;
   logic [WIDTH_PR-1:0]       pr;
   logic [WIDTH_PR-1:0]       divisor_mag;
   logic [WIDTH_PR-1:0]       pr_shift;
   logic [WIDTH_PR:0]         diff;
   logic                      sign_q;
   logic                      sign_r;
   logic                      zero_div;
   logic                      ovf;

   function automatic logic [WIDTH_DIVIDEND-1:0] mag_dividend(input logic signed [WIDTH_DIVIDEND-1:0] v);
      return v[WIDTH_DIVIDEND-1] ? ~v + 1'b1 : v;
   endfunction

   function automatic logic [WIDTH_PR-1:0] mag_divisor(input logic signed [WIDTH_IN-1:0] v);
      logic [WIDTH_PR-1:0] ext;
      ext = {v[WIDTH_IN-1], v};
      return ext[WIDTH_PR-1] ? ~ext + 1'b1 : ext;
   endfunction

   function automatic logic signed [WIDTH_DIVIDEND-1:0] signed_q(input logic neg,
                                                                 input logic [WIDTH_DIVIDEND-1:0] m);
      return neg ? -$signed(m) : $signed(m);
   endfunction

   function automatic logic signed [WIDTH_IN-1:0] signed_r(input logic neg,
                                                           input logic [WIDTH_IN-1:0] m);
      return neg ? -$signed(m) : $signed(m);
   endfunction

   div_controller #(
      .WIDTH_DIVIDEND(WIDTH_DIVIDEND)
   ) u_ctrl (
      .clk      (clk),
      .reset    (reset),
      .valid_in (bus.valid_in),
      .ready_out(bus.ready_out),
      .valid_out(bus.valid_out),
      .capture  (capture),
      .shift    (shift),
      .fix      (fix)
   );

   // pr stays below divisor_mag, so its top bit is zero and {pr, msb} is the zero-extended shift
   always_comb begin
      pr_shift = {pr[WIDTH_PR-2:0], dq[WIDTH_DIVIDEND-1]};
      diff     = {pr, dq[WIDTH_DIVIDEND-1]} - {1'b0, divisor_mag};
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         dq          <= mag_dividend(bus.in_dividend);
         divisor_mag <= mag_divisor(bus.in_divisor);
         sign_q      <= bus.in_dividend[WIDTH_DIVIDEND-1] ^ bus.in_divisor[WIDTH_IN-1];
         sign_r      <= bus.in_dividend[WIDTH_DIVIDEND-1];
         zero_div    <= (bus.in_divisor == '0);
         ovf         <= (bus.in_dividend == {1'b1, {(WIDTH_DIVIDEND-1){1'b0}}}) &&
                        (bus.in_divisor == '1);
         pr          <= '0;
      end else if (shift) begin
         if (!diff[WIDTH_PR]) begin
            pr <= diff[WIDTH_PR-1:0];
            dq <= {dq[WIDTH_DIVIDEND-2:0], 1'b1};
         end else begin
            pr <= pr_shift;
            dq <= {dq[WIDTH_DIVIDEND-2:0], 1'b0};
         end
      end
   end

   // Result registers hold until the next fix-up; divide-by-zero overrides the datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.quotient    <= '0;
         bus.remainder   <= '0;
         bus.div_by_zero <= 1'b0;
         bus.overflow    <= 1'b0;
      end else if (fix) begin
         if (zero_div) begin
            bus.quotient  <= '1;
            bus.remainder <= '0;
         end else begin
            bus.quotient  <= signed_q(sign_q, dq);
            bus.remainder <= signed_r(sign_r, pr[WIDTH_IN-1:0]);
         end
         bus.div_by_zero <= zero_div;
         bus.overflow    <= ovf;
      end
   end
endmodule

// File: tb/tb_booth_divider.sv
// Directed bench for booth_divider: hand-computed quotients, latency, busy-hold and reset abort.
module tb_booth_divider;
   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   lat;
   int   pulses;

   always #5 clk = ~clk;

   booth_divider_if bus();

   booth_divider dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                         input logic [31:0] eq, input logic [15:0] er,
                         input logic edz, input logic eov);
      @(negedge clk);
      bus.valid_in    = 1'b1;
      bus.in_dividend = dvd;
      bus.in_divisor  = dvs;
      @(posedge clk);
      #1 bus.valid_in = 1'b0;
      check({tag, "_busy"}, {31'd0, bus.ready_out}, 32'd0);
      lat = 0;
      while (!bus.valid_out && lat < 60) begin
         @(posedge clk);
         #1 lat++;
      end
      check({tag, "_latency"}, lat, 32'd34);
      check({tag, "_q"}, bus.quotient, eq);
      check({tag, "_r"}, {16'd0, bus.remainder}, {16'd0, er});
      check({tag, "_dz"}, {31'd0, bus.div_by_zero}, {31'd0, edz});
      check({tag, "_ov"}, {31'd0, bus.overflow}, {31'd0, eov});
      @(posedge clk);
      #1;
      check({tag, "_pulse_end"}, {31'd0, bus.valid_out}, 32'd0);
      check({tag, "_q_held"}, bus.quotient, eq);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.valid_in    = 1'b0;
      bus.in_dividend = '0;
      bus.in_divisor  = '0;
      #2;
      check("rst_ready", {31'd0, bus.ready_out}, 32'd1);
      check("rst_valid", {31'd0, bus.valid_out}, 32'd0);
      check("rst_q", bus.quotient, 32'd0);
      check("rst_r", {16'd0, bus.remainder}, 32'd0);
      check("rst_flags", {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      run_op("pos_pos",  32'd100,      16'd7,      32'd14,       16'd2,      1'b0, 1'b0);
      run_op("neg_pos",  32'hFFFFFF9C, 16'd7,      32'hFFFFFFF2, 16'hFFFE,   1'b0, 1'b0);
      run_op("pos_neg",  32'd100,      16'hFFF9,   32'hFFFFFFF2, 16'h0002,   1'b0, 1'b0);
      run_op("neg_neg",  32'hFFFFFFF9, 16'hFFFE,   32'd3,        16'hFFFF,   1'b0, 1'b0);
      run_op("max_pos",  32'h7FFFFFFF, 16'h7FFF,   32'h00010002, 16'h0001,   1'b0, 1'b0);
      run_op("ovf",      32'h80000000, 16'hFFFF,   32'h80000000, 16'h0000,   1'b0, 1'b1);
      run_op("min_min",  32'h80000000, 16'h8000,   32'h00010000, 16'h0000,   1'b0, 1'b0);

      // Op A accepted, B held on valid_in through the whole busy period
      @(negedge clk);
      bus.valid_in    = 1'b1;
      bus.in_dividend = 32'd100;
      bus.in_divisor  = 16'd7;
      @(posedge clk);
      #1;
      bus.in_dividend = 32'd1000;
      bus.in_divisor  = 16'hFFFD;
      pulses = 0;
      repeat (34) begin
         @(posedge clk);
         #1 if (bus.valid_out) pulses++;
      end
      check("hold_a_pulses", pulses, 32'd1);
      check("hold_a_valid", {31'd0, bus.valid_out}, 32'd1);
      check("hold_a_q", bus.quotient, 32'd14);
      check("hold_a_r", {16'd0, bus.remainder}, 32'd2);
      @(posedge clk);
      #1 bus.valid_in = 1'b0;
      check("hold_b_busy", {31'd0, bus.ready_out}, 32'd0);
      pulses = 0;
      repeat (34) begin
         @(posedge clk);
         #1 if (bus.valid_out) pulses++;
      end
      check("hold_b_pulses", pulses, 32'd1);
      check("hold_b_valid", {31'd0, bus.valid_out}, 32'd1);
      check("hold_b_q", bus.quotient, 32'hFFFFFEB3);
      check("hold_b_r", {16'd0, bus.remainder}, 32'd1);

      run_op("div0",     32'h12345678, 16'h0000,   32'hFFFFFFFF, 16'h0000,   1'b1, 1'b0);
      check("div0_flag_held", {31'd0, bus.div_by_zero}, 32'd1);

      // Abort mid-CALC: outputs clear at once, no result ever appears
      @(negedge clk);
      bus.valid_in    = 1'b1;
      bus.in_dividend = 32'd1000;
      bus.in_divisor  = 16'd7;
      @(posedge clk);
      #1 bus.valid_in = 1'b0;
      repeat (10) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("abort_q", bus.quotient, 32'd0);
      check("abort_r", {16'd0, bus.remainder}, 32'd0);
      check("abort_flags", {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);
      check("abort_ready", {31'd0, bus.ready_out}, 32'd1);
      check("abort_valid", {31'd0, bus.valid_out}, 32'd0);
      @(negedge clk);
      reset  = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1 if (bus.valid_out) pulses++;
      end
      check("abort_no_result", pulses, 32'd0);

      run_op("post_rst", 32'd1000,     16'hFFFD,   32'hFFFFFEB3, 16'h0001,   1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential signed divider. It is the inverse companion of the team's radix-2 Booth multiplier and sits beside it in the arithmetic unit.
- It accepts a 2*WIDTH_IN-bit two's-complement dividend and a WIDTH_IN-bit divisor. It returns quotient and remainder after a fixed number of cycles, using a one-bit-per-cycle restoring algorithm on magnitudes.
- It uses the same valid_in/valid_out convention as the multiplier, so both blocks can share one issue path.

Parameters:
- WIDTH_IN, 16, divisor width and remainder width
- WIDTH_DIVIDEND, 32, dividend and quotient width; must equal 2*WIDTH_IN
- WIDTH_PR, 17, partial-remainder width; equals WIDTH_IN+1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- valid_in  in  1  operands valid; sampled only while ready_out=1
- in_dividend  in  WIDTH_DIVIDEND  signed dividend
- in_divisor  in  WIDTH_IN  signed divisor
- ready_out  out  1  high when idle and able to accept
- valid_out  out  1  one-cycle pulse, result valid
- quotient  out  WIDTH_DIVIDEND  signed quotient
- remainder  out  WIDTH_IN  signed remainder
- div_by_zero  out  1  qualifies the result; valid with valid_out
- overflow  out  1  qualifies the result; valid with valid_out

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ready_out=1, valid_out=0. quotient, remainder, div_by_zero and overflow are all 0. Reset mid-operation abandons the division with no valid_out.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - ready_out=1.
  - On an edge with valid_in=1, capture |dividend| into the dividend/quotient shift register and |divisor| into a WIDTH_PR register.
  - Also capture sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend), and the zero/overflow flags.
  - Clear the partial remainder, load the iteration counter with WIDTH_DIVIDEND-1, and go to CALC.
- CALC, one iteration per cycle:
  - pr_shift = {pr[WIDTH_PR-2:0], dq[MSB]}.
  - diff = pr_shift - divisor_mag, computed WIDTH_PR+1 wide.
  - If diff is non-negative: pr = diff and the new quotient LSB = 1. Otherwise: pr = pr_shift and the new LSB = 0.
  - dq shifts left, taking in the new LSB.
  - Exactly WIDTH_DIVIDEND cycles are spent in CALC; leave to FIX when the counter reaches 0.
- FIX:
  - Apply signs: quotient = sign_q ? -q_mag : q_mag; remainder = sign_r ? -pr[WIDTH_IN-1:0] : pr[WIDTH_IN-1:0].
  - Register the results into the output registers.
- DONE: valid_out=1 for this one cycle, then return to IDLE.
- Latency: valid_in is accepted at edge N; valid_out is high in the cycle after edge N+WIDTH_DIVIDEND+2, which is 34 cycles at default.
- Latency is fixed and data-independent, including the special cases below.
- Result semantics: truncation toward zero. The remainder takes the sign of the dividend, or is 0. dividend = quotient*divisor + remainder holds for all non-special cases.
- Divide by zero (in_divisor=0): quotient = all ones, remainder = 0, div_by_zero=1, overflow=0. These values override the datapath result in FIX.
- Overflow (dividend = -2^(WIDTH_DIVIDEND-1) and divisor = -1): quotient = 0x80000000 (wrapped), remainder = 0, overflow=1.
- The magnitude of -2^(WIDTH_DIVIDEND-1) is 2^(WIDTH_DIVIDEND-1), held unsigned in WIDTH_DIVIDEND bits; no other quotient can overflow.
- A divisor magnitude of 2^(WIDTH_IN-1) fits in WIDTH_PR.
- Output registers hold their values after valid_out until the next FIX; flags are likewise held.
- valid_in while ready_out=0, including during DONE, is ignored with no queuing. A new operation may be accepted in the IDLE cycle immediately after DONE.

Decomposition:
- Shared package div_pkg holds:
  - the state enum div_state_e (IDLE, CALC, FIX, DONE);
  - localparams for WIDTH_IN, WIDTH_DIVIDEND and WIDTH_PR;
  - the counter width $clog2(WIDTH_DIVIDEND).
- Split into a datapath top (booth_divider) and one sub-module, div_controller. div_controller owns the state register, the iteration counter, ready_out, valid_out, and the enables for capture, shift and fix. This mirrors the multiplier's datapath/controller split.

Test Plan:
- dividend=100, divisor=7 -> after 34 cycles: valid_out pulse, quotient=14, remainder=2, flags 0.
- dividend=-100, divisor=7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFE (-2); dividend=100, divisor=-7 -> quotient=-14, remainder=2.
- dividend=0x12345678, divisor=0 -> quotient=0xFFFFFFFF, remainder=0, div_by_zero=1, latency still 34.
- dividend=0x80000000, divisor=0xFFFF -> quotient=0x80000000, remainder=0, overflow=1. Also dividend=0x80000000, divisor=0x8000 -> quotient=0x00010000, remainder=0.
- Issue op A; hold valid_in=1 with different operands throughout the busy period -> exactly one valid_out with A's result. The second op is accepted only in the IDLE cycle after DONE and its result appears 34 cycles later.
- Assert reset=0 at cycle 10 of CALC -> all outputs 0 immediately, ready_out=1, no valid_out. A subsequent 1000/-3 gives quotient=-333, remainder=1.
